// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch buffer: issues word reads to a 1-cycle ROM and
// queues {address, instruction} pairs for the core behind a valid/ready handshake.
module if_prefetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic        inflight_q, inflight_d;
  logic        drop_q, drop_d;
  logic        rst_q;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [63:0]   mem_q [DEPTH];

  logic          issue, push, pop, not_empty;
  logic [AW+1:0] occupancy;

  // Credit counts the outstanding request so a return always has a free slot.
  assign occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, inflight_q};
  assign issue     = !rst_q && !jump_en_i && (occupancy < (AW+2)'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = inflight_q && !drop_q && !jump_en_i;
  assign pop       = not_empty && inst_ready_i && !jump_en_i;

  assign rom_req_o    = issue;
  assign rom_addr_o   = pc_q;
  assign inst_valid_o = not_empty;
  assign inst_o       = not_empty ? mem_q[rd_q][31:0]  : NOP_INST;
  assign inst_addr_o  = not_empty ? mem_q[rd_q][63:32] : 32'h0;

  always_comb begin
    pc_d       = pc_q;
    pc_req_d   = pc_req_q;
    inflight_d = issue;
    drop_d     = 1'b0;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (jump_en_i) begin
      pc_d    = jump_addr_i & ~32'h3;
      drop_d  = inflight_q;
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (issue) begin
        pc_d     = pc_q + 32'd4;
        pc_req_d = pc_q;
      end
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_ADDR;
      pc_req_q   <= 32'h0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      rst_q      <= 1'b1;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_req_q   <= pc_req_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rst_q      <= 1'b0;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q gates every read,
  // so stale contents are never visible and the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {pc_req_q, rom_data_i};
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: stream, stall, jump, push+pop, wrap and mid-stream reset.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        ready = 1'b0;

  logic        req_a, valid_a, req_b, valid_b;
  logic [31:0] raddr_a, rdata_a, inst_a, iaddr_a;
  logic [31:0] raddr_b, rdata_b, inst_b, iaddr_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_prefetch u_dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .rom_req_o(req_a), .rom_addr_o(raddr_a), .rom_data_i(rdata_a),
    .inst_valid_o(valid_a), .inst_ready_i(ready), .inst_o(inst_a), .inst_addr_o(iaddr_a)
  );

  if_prefetch #(.RESET_ADDR(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .rom_req_o(req_b), .rom_addr_o(raddr_b), .rom_data_i(rdata_b),
    .inst_valid_o(valid_b), .inst_ready_i(ready), .inst_o(inst_b), .inst_addr_o(iaddr_b)
  );

  // ROM model: word at byte address A holds A/4, returned one cycle after the request.
  always @(posedge clk) begin
    if (req_a) rdata_a <= raddr_a >> 2;
    if (req_b) rdata_b <= raddr_b >> 2;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; jump_en = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    ready = 1'b1;
    #1;
    if (req_a !== 1'b0)        begin n_err++; $display("FAIL rst_req: got %b expected 0", req_a); end
    n_vec++;
    if (valid_a !== 1'b0)      begin n_err++; $display("FAIL rst_valid: got %b expected 0", valid_a); end
    n_vec++;
    if (inst_a !== 32'h13)     begin n_err++; $display("FAIL rst_inst: got %h expected 00000013", inst_a); end
    n_vec++;
    if (iaddr_a !== 32'h0)     begin n_err++; $display("FAIL rst_iaddr: got %h expected 0", iaddr_a); end
    n_vec++;
    if (raddr_a !== 32'h0)     begin n_err++; $display("FAIL rst_raddr: got %h expected 0", raddr_a); end
    n_vec++;
    if (raddr_b !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL rst_raddr_wrap: got %h expected fffffff8", raddr_b); end
    n_vec++;
  endtask

  task automatic test_stream();
    do_reset();
    ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      #1;
      if (req_a !== (c >= 1)) begin n_err++; $display("FAIL stream_req c%0d: got %b expected %b", c, req_a, c >= 1); end
      n_vec++;
      if (c >= 1 && raddr_a !== 32'(4 * (c - 1))) begin
        n_err++; $display("FAIL stream_raddr c%0d: got %h expected %h", c, raddr_a, 4 * (c - 1));
      end
      if (c >= 1) n_vec++;
      if (valid_a !== (c >= 3)) begin n_err++; $display("FAIL stream_valid c%0d: got %b expected %b", c, valid_a, c >= 3); end
      n_vec++;
      if (c >= 3) begin
        if (inst_a !== 32'(c - 3))       begin n_err++; $display("FAIL stream_inst c%0d: got %h expected %h", c, inst_a, c - 3); end
        if (iaddr_a !== 32'(4 * (c - 3))) begin n_err++; $display("FAIL stream_iaddr c%0d: got %h expected %h", c, iaddr_a, 4 * (c - 3)); end
        n_vec += 2;
      end
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    int got = 0;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      #1;
      if (req_a) begin
        if (raddr_a !== 32'(4 * nreq)) begin n_err++; $display("FAIL stall_raddr: got %h expected %h", raddr_a, 4 * nreq); end
        n_vec++;
        nreq++;
      end
    end
    if (nreq != 4)       begin n_err++; $display("FAIL stall_nreq: got %0d expected 4", nreq); end
    n_vec++;
    if (req_a !== 1'b0)  begin n_err++; $display("FAIL stall_req_idle: got %b expected 0", req_a); end
    n_vec++;
    ready = 1'b1;
    #1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (valid_a) begin
        if (iaddr_a !== 32'(4 * got)) begin n_err++; $display("FAIL stall_drain_addr %0d: got %h expected %h", got, iaddr_a, 4 * got); end
        if (inst_a !== 32'(got))      begin n_err++; $display("FAIL stall_drain_inst %0d: got %h expected %h", got, inst_a, got); end
        n_vec += 2;
        got++;
      end
      @(negedge clk);
      #1;
    end
    if (got != 5) begin n_err++; $display("FAIL stall_drain_count: got %0d expected 5", got); end
    n_vec++;
  endtask

  task automatic test_jump();
    do_reset();
    ready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      jump_en = (c == 5 || c == 10 || c == 11);
      jump_addr = (c == 5) ? 32'h103 : (c == 10) ? 32'h200 : 32'h305;
      #1;
      case (c)
        5:  cmp("jump_noissue", {31'h0, req_a}, 32'h0);
        6:  begin
              cmp("jump_req", {31'h0, req_a}, 32'h1);
              cmp("jump_raddr", raddr_a, 32'h100);
              cmp("jump_valid1", {31'h0, valid_a}, 32'h0);
            end
        7:  begin
              cmp("jump_valid2", {31'h0, valid_a}, 32'h0);
              cmp("jump_raddr2", raddr_a, 32'h104);
            end
        8:  begin
              cmp("jump_first_valid", {31'h0, valid_a}, 32'h1);
              cmp("jump_first_iaddr", iaddr_a, 32'h100);
              cmp("jump_first_inst", inst_a, 32'h40);
            end
        9:  cmp("jump_second_iaddr", iaddr_a, 32'h104);
        12: begin
              cmp("b2b_raddr", raddr_a, 32'h304);
              cmp("b2b_valid", {31'h0, valid_a}, 32'h0);
            end
        13: cmp("b2b_valid2", {31'h0, valid_a}, 32'h0);
        14: begin
              cmp("b2b_iaddr", iaddr_a, 32'h304);
              cmp("b2b_inst", inst_a, 32'hC1);
            end
        default: ;
      endcase
    end
    jump_en = 1'b0;
  endtask

  task automatic test_full_pushpop();
    logic [15:0] pat = 16'b1101_1101_0110_1011;
    int got = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      #1;
    end
    cmp("full_valid", {31'h0, valid_a}, 32'h1);
    cmp("full_noreq", {31'h0, req_a}, 32'h0);
    for (int i = 0; i < 60 && got < 10; i++) begin
      @(negedge clk);
      ready = pat[i % 16];
      #1;
      if (valid_a && ready) begin
        if (iaddr_a !== 32'(4 * got)) begin n_err++; $display("FAIL pp_addr %0d: got %h expected %h", got, iaddr_a, 4 * got); end
        if (inst_a !== 32'(got))      begin n_err++; $display("FAIL pp_inst %0d: got %h expected %h", got, inst_a, got); end
        n_vec += 2;
        got++;
      end
    end
    if (got != 10) begin n_err++; $display("FAIL pp_count: got %0d expected 10", got); end
    n_vec++;
  endtask

  task automatic test_wrap();
    logic [31:0] seq [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    ready = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      #1;
      if (c >= 1 && c <= 3) cmp("wrap_raddr", raddr_b, seq[c - 1]);
      if (c >= 3) begin
        cmp("wrap_iaddr", iaddr_b, seq[c - 3]);
        cmp("wrap_inst", inst_b, seq[c - 3] >> 2);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      if (c == 5) rst = 1'b1;
      if (c == 6) rst = 1'b0;
      if (c == 7) ready = 1'b1;
      #1;
      case (c)
        5: cmp("mr_pre_valid", {31'h0, valid_a}, 32'h1);
        6: begin
             cmp("mr_valid", {31'h0, valid_a}, 32'h0);
             cmp("mr_inst", inst_a, 32'h13);
             cmp("mr_iaddr", iaddr_a, 32'h0);
             cmp("mr_noreq", {31'h0, req_a}, 32'h0);
           end
        7: begin
             cmp("mr_req", {31'h0, req_a}, 32'h1);
             cmp("mr_raddr", raddr_a, 32'h0);
           end
        8: cmp("mr_valid_gap", {31'h0, valid_a}, 32'h0);
        9: begin
             cmp("mr_refetch_valid", {31'h0, valid_a}, 32'h1);
             cmp("mr_refetch_iaddr", iaddr_a, 32'h0);
             cmp("mr_refetch_inst", inst_a, 32'h0);
           end
        default: ;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_full_pushpop();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
